// File: rtl/uart_receiver_if.sv
// Result side of the UART receiver: received word, one-cycle status pulses and busy.
// The receiver drives through master and the register/processor side reads through slave.
interface uart_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output parallel_data,
    output data_valid,
    output par_err,
    output stp_err,
    output busy
  );

  modport slave (
    input parallel_data,
    input data_valid,
    input par_err,
    input stp_err,
    input busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Each bit is taken as the 3-sample majority around mid-bit; status is reported as one-cycle pulses.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ser_data_in,
  input  logic            par_en,
  input  logic            par_type,
  uart_receiver_if.master rx_if
);

  localparam int EW = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] SMP_A    = EW'(PRESCALE/2 - 1);
  localparam logic [EW-1:0] SMP_B    = EW'(PRESCALE/2);
  localparam logic [EW-1:0] SMP_V    = EW'(PRESCALE/2 + 1);
  localparam logic [EW-1:0] EDGE_END = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef struct packed {
    logic valid;
    logic par_err;
    logic stp_err;
  } rx_rsp_t;

  state_t                state, state_d;
  logic [1:0]            sync_q;
  logic                  rx;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  smp_a, smp_b;
  logic                  vote;
  logic                  at_vote, at_end;
  logic                  detect;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_type_q;
  logic                  par_fail, stp_fail;
  rx_rsp_t               rsp_q;

  // Line is asynchronous; idle-high reset keeps a reset release from looking like a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], ser_data_in};
  end
  assign rx = sync_q[1];

  assign vote    = (smp_a & smp_b) | (smp_a & rx) | (smp_b & rx);
  assign at_vote = (edge_cnt == SMP_V);
  assign at_end  = (edge_cnt == EDGE_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d    = state;
    detect     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          detect  = 1'b1;
        end
      end
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_end)     state_d = DATA;
      end
      DATA: begin
        if (at_end && (bit_cnt == BIT_END)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end) state_d = STOP;
      end
      STOP: begin
        if (at_end) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
    end else begin
      if (detect)                 edge_cnt <= EW'(1);
      else if (state_d == IDLE)   edge_cnt <= '0;
      else if (at_end)            edge_cnt <= '0;
      else                        edge_cnt <= edge_cnt + EW'(1);

      if (state == IDLE)               bit_cnt <= '0;
      else if (state == DATA && at_end) bit_cnt <= bit_cnt + BW'(1);

      if (edge_cnt == SMP_A) smp_a <= rx;
      if (edge_cnt == SMP_B) smp_b <= rx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_fail   <= 1'b0;
      stp_fail   <= 1'b0;
    end else begin
      if (detect) begin
        par_en_q   <= par_en;
        par_type_q <= par_type;
        par_fail   <= 1'b0;
        stp_fail   <= 1'b0;
      end
      if (state == DATA && at_vote) shreg[bit_cnt] <= vote;
      if (state == PARITY && at_vote && (vote != (^shreg ^ par_type_q))) par_fail <= 1'b1;
      if (state == STOP && at_vote && !vote) stp_fail <= 1'b1;
    end
  end

  // Pulses land in the cycle the FSM is already back in IDLE; a bad frame leaves data_q untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q  <= '0;
      data_q <= '0;
    end else begin
      rsp_q <= '0;
      if (frame_done) begin
        rsp_q.valid   <= !par_fail && !stp_fail;
        rsp_q.par_err <= par_fail;
        rsp_q.stp_err <= stp_fail;
        if (!par_fail && !stp_fail) data_q <= shreg;
      end
    end
  end

  assign rx_if.parallel_data = data_q;
  assign rx_if.data_valid    = rsp_q.valid;
  assign rx_if.par_err       = rsp_q.par_err;
  assign rx_if.stp_err       = rsp_q.stp_err;
  assign rx_if.busy          = (state != IDLE);

endmodule
